// File: rtl/add_share_arb_pkg.sv
// rtl/add_share_arb_pkg.sv - widths and operator decode constants for the shared add/sub arbiter
`include "admo_defs.v"

package add_share_arb_pkg;

  localparam int DATA_W  = `DATA_WIDTH;
  localparam int OP_W    = 4;
  localparam int SUB_BIT = `ALU_SUB_BIT;

endpackage

// File: rtl/add_share_arb_if.sv
// rtl/add_share_arb_if.sv - requester and response handshake bundle for add_share_arb
interface add_share_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
);
  import add_share_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*DATA_W-1:0] req_operand_a_i;
  logic [NUM_REQ*DATA_W-1:0] req_operand_b_i;
  logic [NUM_REQ*OP_W-1:0]   req_operator_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [DATA_W-1:0]         rsp_result_o;
  logic [ID_W-1:0]           rsp_id_o;

  modport slave (
    input  req_valid_i, req_operand_a_i, req_operand_b_i, req_operator_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o
  );

  modport master (
    output req_valid_i, req_operand_a_i, req_operand_b_i, req_operator_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o
  );

endinterface

// File: rtl/add_share_pick.sv
// rtl/add_share_pick.sv - combinational rotate-priority picker; search begins just after i_last
module add_share_pick #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_any
);

  // Two passes replace a modulo walk: indices above last first, then wrap to 0..last.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    o_any      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && i_valid[k] && (k > int'(i_last))) begin
        o_grant[k] = 1'b1;
        o_grant_id = ID_W'(k);
        o_any      = 1'b1;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && i_valid[k] && (k <= int'(i_last))) begin
        o_grant[k] = 1'b1;
        o_grant_id = ID_W'(k);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/admo_defs.v
// rtl/admo_defs.v - shared datapath width and ALU operator codes
`ifndef ADMO_DEFS_V
`define ADMO_DEFS_V

`define DATA_WIDTH  32
`define ALU_ADD     4'b0000
`define ALU_SUB     4'b1000
`define ALU_SUB_BIT 3

`endif

// File: rtl/add_share_arb.sv
// rtl/add_share_arb.sv - NUM_REQ-way arbiter over one 32-bit add/sub with a registered response slot
// ADD_SHARE_ARB_RR_EN defined: round-robin; undefined: fixed priority, lowest index wins.
module add_share_arb
  import add_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  add_share_arb_if.slave bus
);

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W-1:0]    w_last;
  logic               w_any;
  logic               w_slot_free;
  logic               w_accept;
  logic [DATA_W-1:0]  w_op_a;
  logic [DATA_W-1:0]  w_op_b;
  logic [DATA_W-1:0]  w_b_eff;
  logic [DATA_W-1:0]  w_sum;
  logic [OP_W-1:0]    w_op;
  logic               w_sub;
  logic               w_unused_op;

  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_result;
  logic [ID_W-1:0]    r_rsp_id;

`ifdef ADD_SHARE_ARB_RR_EN
  logic [ID_W-1:0]    r_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= LAST_RST;
    end else if (w_accept) begin
      r_last <= w_grant_id;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = LAST_RST;
`endif

  add_share_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_valid    (bus.req_valid_i),
    .i_last     (w_last),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_any      (w_any)
  );

  assign w_slot_free     = !r_rsp_valid || bus.rsp_ready_i;
  assign bus.req_ready_o = w_grant & {NUM_REQ{w_slot_free}};
  assign w_accept        = w_any && w_slot_free;

  // One-hot grant mux; only the granted requester's operands reach the adder.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    w_op   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_op_a = bus.req_operand_a_i[k*DATA_W +: DATA_W];
        w_op_b = bus.req_operand_b_i[k*DATA_W +: DATA_W];
        w_op   = bus.req_operator_i[k*OP_W +: OP_W];
      end
    end
  end

  assign w_sub       = w_op[SUB_BIT];
  assign w_unused_op = ^w_op[SUB_BIT-1:0];
  assign w_b_eff     = w_sub ? ~w_op_b : w_op_b;
  assign w_sum       = w_op_a + w_b_eff + DATA_W'(w_sub);

  // Result and id only move on accept so a pure drain leaves the last values visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
    end else if (w_accept) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= w_sum;
      r_rsp_id     <= w_grant_id;
    end else if (bus.rsp_ready_i) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_result_o = r_rsp_result;
  assign bus.rsp_id_o     = r_rsp_id;

endmodule
